// File: rtl/municao_jogador.sv
// Player projectile: launches from the ship on a fire press, climbs one step per move
// tick, pulses acerto on an enemy hit, then waits out a reload cooldown before re-arming.
module municao_jogador #(
  parameter int unsigned DELAY_MOVIMENTO = 500000,
  parameter int unsigned PASSO           = 1,
  parameter int unsigned COOLDOWN        = 25000000,
  parameter int unsigned LARG_TIRO       = 2,
  parameter int unsigned COMPR_TIRO      = 20,
  parameter int unsigned LARG_INIMIGO    = 40,
  parameter int unsigned ALT_INIMIGO     = 30,
  parameter int unsigned H_BORDA         = 96,
  parameter int unsigned V_BORDA         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_fire,
  input  logic [10:0] posX_nave,
  input  logic [10:0] posY_nave,
  input  logic [10:0] posX_inimigo,
  input  logic [10:0] posY_inimigo,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  output logic [10:0] posX_municao,
  output logic [10:0] posY_municao,
  output logic        tiro_ativo,
  output logic        acerto,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B
);

  localparam int MOV_W = $clog2(DELAY_MOVIMENTO + 1);
  localparam int CD_W  = $clog2(COOLDOWN + 1);
  localparam logic [MOV_W-1:0] MOV_MAX = MOV_W'(DELAY_MOVIMENTO - 1);
  localparam logic [CD_W-1:0]  CD_MAX  = CD_W'(COOLDOWN - 1);

  typedef enum logic [1:0] {IDLE, VOO, ACERTO, RECARGA} estado_t;

  estado_t          estado;
  logic [MOV_W-1:0] mov_cnt;
  logic [CD_W-1:0]  cd_cnt;
  logic             sync1, sync2, sync3;
  logic             fire_pulse;
  logic             tick;
  logic             hit;
  logic             borda;
  logic             pixel_tiro;
  logic [10:0]      h_ext, v_ext;
  logic [11:0]      inim_x_fim, inim_y_fim, tiro_x_fim, tiro_y_fim;

  assign fire_pulse = sync2 & ~sync3;
  assign tick       = (mov_cnt == MOV_MAX);

  // Bounds are summed one bit wider so a hitbox or shot near the right/bottom edge never wraps.
  assign inim_x_fim = {1'b0, posX_inimigo} + 12'(LARG_INIMIGO);
  assign inim_y_fim = {1'b0, posY_inimigo} + 12'(ALT_INIMIGO);
  assign tiro_x_fim = {1'b0, posX_municao} + 12'(LARG_TIRO);
  assign tiro_y_fim = {1'b0, posY_municao} + 12'(COMPR_TIRO);

  assign hit = (posX_municao >= posX_inimigo) && ({1'b0, posX_municao} < inim_x_fim) &&
               (posY_municao >= posY_inimigo) && ({1'b0, posY_municao} < inim_y_fim);

  assign h_ext = {1'b0, h_counter};
  assign v_ext = {1'b0, v_counter};
  assign borda = (v_counter <= 10'(V_BORDA)) || (h_counter <= 10'(H_BORDA));
  assign pixel_tiro = tiro_ativo &&
                      (h_ext >= posX_municao) && ({1'b0, h_ext} < tiro_x_fim) &&
                      (v_ext >= posY_municao) && ({1'b0, v_ext} < tiro_y_fim);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado       <= IDLE;
      mov_cnt      <= '0;
      cd_cnt       <= '0;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      posX_municao <= '0;
      posY_municao <= '0;
      tiro_ativo   <= 1'b0;
      acerto       <= 1'b0;
      R            <= '0;
      G            <= '0;
      B            <= '0;
    end else begin
      sync1  <= btn_fire;
      sync2  <= sync1;
      sync3  <= sync2;
      acerto <= 1'b0;

      if (!borda && pixel_tiro) begin
        R <= 8'hFF;
        G <= 8'hFF;
        B <= 8'h00;
      end else begin
        R <= 8'h00;
        G <= 8'h00;
        B <= 8'h00;
      end

      // Fire pulses outside IDLE fall through every branch below and are simply lost.
      case (estado)
        IDLE: begin
          if (fire_pulse) begin
            posX_municao <= posX_nave;
            posY_municao <= posY_nave;
            mov_cnt      <= '0;
            tiro_ativo   <= 1'b1;
            estado       <= VOO;
          end
        end
        VOO: begin
          if (hit) begin
            acerto     <= 1'b1;
            tiro_ativo <= 1'b0;
            estado     <= ACERTO;
          end else if (tick) begin
            mov_cnt <= '0;
            if (posY_municao <= 11'(PASSO)) begin
              tiro_ativo <= 1'b0;
              cd_cnt     <= '0;
              estado     <= RECARGA;
            end else begin
              posY_municao <= posY_municao - 11'(PASSO);
            end
          end else begin
            mov_cnt <= mov_cnt + 1'b1;
          end
        end
        ACERTO: begin
          cd_cnt <= '0;
          estado <= RECARGA;
        end
        RECARGA: begin
          if (cd_cnt == CD_MAX) begin
            cd_cnt <= '0;
            estado <= IDLE;
          end else begin
            cd_cnt <= cd_cnt + 1'b1;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule
